// File: rtl/ycbcr_422_packer.sv
// ycbcr_422_packer: 4:4:4 -> 4:2:2 conversion. Chroma of each pixel pair is
// averaged with round-half-up, the pair is stored in a small FIFO and then
// serialized as two {chroma,luma} words on a valid/ready output.
module ycbcr_422_packer #(
    parameter int DATA_W     = 8,
    parameter int LINE_WIDTH = 640,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_i,
    input  logic                          data_valid_i,
    input  logic [DATA_W-1:0]             y_i,
    input  logic [DATA_W-1:0]             cb_i,
    input  logic [DATA_W-1:0]             cr_i,
    output logic                          dout_valid_o,
    input  logic                          dout_ready_i,
    output logic [2*DATA_W-1:0]           dout_o,
    output logic                          dout_eol_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_W   = $clog2(LINE_WIDTH);
    localparam int ENTRY_W = 4*DATA_W + 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(LINE_WIDTH - 1);

    typedef enum logic {EVEN, ODD} pair_state_t;

    pair_state_t          state, state_next;
    logic [DATA_W-1:0]    y0, cb0, cr0;
    logic [CNT_W-1:0]     pix_cnt;
    logic [DATA_W:0]      cb_sum, cr_sum;
    logic                 push, push_ok, pop, handshake;
    logic                 phase, overflow;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [ENTRY_W-1:0]   entry_in, entry_out;

    // Pair FSM state register
    always_ff @(posedge clk) begin
        if (rst_i) state <= EVEN;
        else       state <= state_next;
    end

    // Pair FSM next state: toggles on every accepted pixel
    always_comb begin
        state_next = state;
        if (data_valid_i) state_next = (state == EVEN) ? ODD : EVEN;
    end

    // Pair FSM output: a completed pair is offered to the FIFO on the odd pixel
    always_comb begin
        push = 1'b0;
        if (data_valid_i && state == ODD) push = 1'b1;
    end

    // Hold the even pixel until its partner arrives
    always_ff @(posedge clk) begin
        if (data_valid_i && state == EVEN) begin
            y0  <= y_i;
            cb0 <= cb_i;
            cr0 <= cr_i;
        end
    end

    // Accepted-pixel counter within the line
    always_ff @(posedge clk) begin
        if (rst_i)             pix_cnt <= '0;
        else if (data_valid_i) pix_cnt <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + CNT_W'(1);
    end

    // Sums are one bit wider so 255+255+1 does not wrap
    assign cb_sum   = {1'b0, cb0} + {1'b0, cb_i} + (DATA_W+1)'(1);
    assign cr_sum   = {1'b0, cr0} + {1'b0, cr_i} + (DATA_W+1)'(1);
    assign entry_in = {cb_sum[DATA_W:1], y0, cr_sum[DATA_W:1], y_i, (pix_cnt == LAST_PIX)};

    assign dout_valid_o = (level != '0);
    assign handshake    = dout_valid_o && dout_ready_i;
    assign pop          = handshake && phase;
    // When full, a same-cycle pop frees the slot the write lands in
    assign push_ok      = push && ((level < LVL_W'(FIFO_DEPTH)) || pop);

    // Pair storage; validity is tracked by level, so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= entry_in;
    end

    // FIFO pointers, level, serializer phase and sticky overflow
    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            phase    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (handshake)        phase    <= ~phase;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    assign entry_out = mem[rd_ptr];

    // Word serializer: phase 0 sends {Cb,Y0}, phase 1 sends {Cr,Y1} with eol
    always_comb begin
        dout_o     = '0;
        dout_eol_o = 1'b0;
        if (dout_valid_o) begin
            if (phase) begin
                dout_o     = entry_out[2*DATA_W:1];
                dout_eol_o = entry_out[0];
            end else begin
                dout_o     = entry_out[4*DATA_W:2*DATA_W+1];
            end
        end
    end

    assign fifo_level_o = level;
    assign overflow_o   = overflow;

endmodule
